// File: rtl/regfile_pkg.sv
// Shared register-file constants for the writeback arbiter slice.
package regfile_pkg;
   localparam int unsigned RF_DATA_WIDTH = 32;
   localparam int unsigned RF_ADDR_WIDTH = 5;
   localparam int unsigned NUM_REGS      = 32;
   localparam int unsigned REG_ZERO      = 0;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping; also returns the pointer that follows the grant.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PW-1:0]      next_ptr
);

   logic          found;
   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   always_comb begin
      grant    = '0;
      next_ptr = ptr;
      found    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         // One extra bit so ptr+off cannot overflow before the modulo wrap.
         sum = {1'b0, ptr} + (PW+1)'(off);
         if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
         idx = sum[PW-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            next_ptr   = (idx == PW'(NUM_REQ-1)) ? '0 : idx + PW'(1);
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter with destination scoreboard and registered write stage.
// Optional write-cycle forwarding outputs when REGFILE_ARB_FWD_EN is defined.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int unsigned NUM_REQ    = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic                          rsv_valid,
   input  logic [ADDR_WIDTH-1:0]         rsv_addr,
   input  logic [ADDR_WIDTH-1:0]         chk_addr_1,
   input  logic [ADDR_WIDTH-1:0]         chk_addr_2,
   output logic                          chk_busy_1,
   output logic                          chk_busy_2,
   output logic [DATA_WIDTH-1:0]         rf_write_data,
   output logic [ADDR_WIDTH-1:0]         rf_write_address,
   output logic                          rf_reg_write
`ifdef REGFILE_ARB_FWD_EN
   ,
   output logic                          fwd_hit_1,
   output logic                          fwd_hit_2,
   output logic [DATA_WIDTH-1:0]         fwd_data_1,
   output logic [DATA_WIDTH-1:0]         fwd_data_2
`endif
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         rr_next;
   logic [NUM_REQ-1:0]    grant;
   logic                  xfer;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [NUM_REGS-1:0]   busy;
   logic [NUM_REGS-1:0]   busy_next;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req      (req_valid),
      .ptr      (rr_ptr),
      .grant    (grant),
      .next_ptr (rr_next)
   );

   always_comb begin
      req_ready = grant & {NUM_REQ{rst_n}};
      xfer      = |req_ready;
      sel_addr  = '0;
      sel_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Reserve is applied after clear so a newer pending writer of the same register wins.
   always_comb begin
      busy_next = busy;
      if (xfer) busy_next[sel_addr] = 1'b0;
      if (rsv_valid && rsv_addr != ZERO_ADDR) busy_next[rsv_addr] = 1'b1;
   end

   always_comb begin
      chk_busy_1 = busy[chk_addr_1] |
                   (rsv_valid && rsv_addr == chk_addr_1 && chk_addr_1 != ZERO_ADDR);
      chk_busy_2 = busy[chk_addr_2] |
                   (rsv_valid && rsv_addr == chk_addr_2 && chk_addr_2 != ZERO_ADDR);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr           <= '0;
         busy             <= '0;
         rf_reg_write     <= 1'b0;
         rf_write_address <= '0;
         rf_write_data    <= '0;
      end else begin
         busy         <= busy_next;
         rf_reg_write <= xfer && sel_addr != ZERO_ADDR;
         if (xfer) rr_ptr <= rr_next;
         if (xfer && sel_addr != ZERO_ADDR) begin
            rf_write_address <= sel_addr;
            rf_write_data    <= sel_data;
         end
      end
   end

`ifdef REGFILE_ARB_FWD_EN
   always_comb begin
      fwd_hit_1  = rf_reg_write && rf_write_address == chk_addr_1 && chk_addr_1 != ZERO_ADDR;
      fwd_hit_2  = rf_reg_write && rf_write_address == chk_addr_2 && chk_addr_2 != ZERO_ADDR;
      fwd_data_1 = rf_write_data;
      fwd_data_2 = rf_write_data;
   end
`endif

endmodule
